// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word load/store into a word array with programmable wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module dmem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic [31:0] daddr_i,
   input  logic [31:0] dwdata_i,
   input  logic [1:0]  dsize_i,
   input  logic        drd_i,
   input  logic        dwr_i,
   output logic [31:0] drdata_o,
   output logic        dready_o,
   output logic        derr_o,
   output logic        busy_o
);

   localparam int         AW        = $clog2(DEPTH);
   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [1:0]    size_q, size_d;
   logic          rd_q, rd_d;
   logic          wr_q, wr_d;
   logic          err_q, err_d;
   logic [31:0]   drdata_q, drdata_d;

   logic [31:0]   mem [DEPTH];

   logic [AW+1:0] acc_addr;
   logic [31:0]   acc_wdata;
   logic [1:0]    acc_size;
   logic          acc_rd, acc_wr, acc_err;
   logic [AW-1:0] acc_idx;
   logic [1:0]    acc_off;
   logic [3:0]    acc_be;
   logic [31:0]   acc_lane;
   logic          enter_resp;
   logic          mem_we;
   logic          addr_hi_unused;

   // Upper address bits select nothing: the array wraps modulo DEPTH*4 bytes.
   assign addr_hi_unused = ^daddr_i[31:AW+2];

   // The access that commits on RESP entry comes straight from the inputs when
   // there are no wait states, otherwise from the latched request.
   always_comb begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      if (state_q == ST_IDLE) begin
         acc_addr  = daddr_i[AW+1:0];
         acc_wdata = dwdata_i;
         acc_size  = dsize_i;
         acc_rd    = drd_i;
         acc_wr    = dwr_i;
      end
   end

   assign acc_idx = acc_addr[AW+1:2];
   assign acc_off = acc_addr[1:0];

   always_comb begin
      acc_be   = 4'b1111;
      acc_lane = acc_wdata;
      case (acc_size)
         SIZE_BYTE: begin
            acc_be   = 4'b0001 << acc_off;
            acc_lane = {4{acc_wdata[7:0]}};
         end
         SIZE_HALF: begin
            acc_be   = acc_off[1] ? 4'b1100 : 4'b0011;
            acc_lane = {2{acc_wdata[15:0]}};
         end
         default: begin
            acc_be   = 4'b1111;
            acc_lane = acc_wdata;
         end
      endcase
`ifdef DMEM_MISALIGN_TRAP_EN
      acc_err = (acc_rd & acc_wr)
              | ((acc_size == SIZE_HALF) & acc_off[0])
              | ((acc_size != SIZE_HALF) & (acc_size != SIZE_BYTE) & (|acc_off));
`else
      acc_err = acc_rd & acc_wr;
`endif
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      size_d     = size_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      err_d      = err_q;
      drdata_d   = drdata_q;
      enter_resp = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drd_i | dwr_i) begin
               addr_d  = daddr_i[AW+1:0];
               wdata_d = dwdata_i;
               size_d  = dsize_i;
               rd_d    = drd_i;
               wr_d    = dwr_i;
               cnt_d   = WAIT_INIT;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
               end else begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // Error responses read as zero; write responses leave the read data alone.
      if (enter_resp) begin
         err_d = acc_err;
         if (acc_err) begin
            drdata_d = 32'h0;
         end else if (acc_rd) begin
            drdata_d = mem[acc_idx];
         end
      end
   end

   assign mem_we = enter_resp & acc_wr & ~acc_err & ~reset_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         size_q   <= 2'd0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         err_q    <= 1'b0;
         drdata_q <= 32'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         size_q   <= size_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         err_q    <= err_d;
         drdata_q <= drdata_d;
      end
   end

   // Array contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (mem_we && acc_be[i]) begin
            mem[acc_idx][8*i +: 8] <= acc_lane[8*i +: 8];
         end
      end
   end

   assign drdata_o = drdata_q;
   assign dready_o = (state_q == ST_RESP);
   assign derr_o   = (state_q == ST_RESP) & err_q;
   assign busy_o   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances with 0, 3 and 2 wait states, vector table plus
// hand sequences for wait-state input isolation and reset mid-transaction.
module tb_dmem_responder;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic        clk;
   logic        rst    [3];
   logic [31:0] daddr  [3];
   logic [31:0] dwdata [3];
   logic [1:0]  dsize  [3];
   logic        drd    [3];
   logic        dwr    [3];
   logic [31:0] drdata [3];
   logic        dready [3];
   logic        derr   [3];
   logic        busy   [3];

   logic [32:0] exp_q[$];
   vec_t        tbl[$];
   int          n_chk  = 0;
   int          n_pass = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      dmem_responder #(
         .DEPTH(1024),
         .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2))
      ) u_dut (
         .clk_i(clk),
         .reset_i(rst[g]),
         .daddr_i(daddr[g]),
         .dwdata_i(dwdata[g]),
         .dsize_i(dsize[g]),
         .drd_i(drd[g]),
         .dwr_i(dwr[g]),
         .drdata_o(drdata[g]),
         .dready_o(dready[g]),
         .derr_o(derr[g]),
         .busy_o(busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
   endfunction

   function automatic vec_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic e, input logic [31:0] r);
      vec_t v;
      v.rd = rd; v.wr = wr; v.size = sz; v.addr = a; v.wdata = d; v.err = e; v.rdata = r;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one request, then wait (bounded) for its response and score it.
   task automatic do_txn(input int k, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic e, input logic [31:0] r, input string name);
      int          lat;
      logic [32:0] exp;
      drd[k] = rd; dwr[k] = wr; dsize[k] = sz; daddr[k] = a; dwdata[k] = d;
      exp_q.push_back({e, r});
      tick();
      drd[k] = 1'b0; dwr[k] = 1'b0;
      lat = 1;
      while (!dready[k] && lat < 20) begin
         check({name, "_busy_wait"}, 32'(busy[k]), 32'd1);
         tick();
         lat++;
      end
      exp = exp_q.pop_front();
      if (dready[k]) begin
         check({name, "_latency"}, 32'(lat), 32'(ws_of(k) + 1));
         check({name, "_busy_resp"}, 32'(busy[k]), 32'd1);
         check({name, "_err"}, 32'(derr[k]), 32'(exp[32]));
         check({name, "_rdata"}, drdata[k], exp[31:0]);
      end else begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end
      tick();
      check({name, "_pulse_end"}, 32'(dready[k]), 32'd0);
      check({name, "_idle"}, 32'(busy[k]), 32'd0);
   endtask

   initial begin
      logic [31:0] hold20;
      logic [31:0] lr;
      logic [31:0] a;
      logic [31:0] d;
      logic [32:0] exp;

      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; drd[k] = 1'b0; dwr[k] = 1'b0;
         dsize[k] = SZ_W; daddr[k] = 32'h0; dwdata[k] = 32'h0;
      end
      repeat (3) tick();
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset_dready%0d", k), 32'(dready[k]), 32'd0);
         check($sformatf("reset_derr%0d", k), 32'(derr[k]), 32'd0);
         check($sformatf("reset_busy%0d", k), 32'(busy[k]), 32'd0);
         check($sformatf("reset_drdata%0d", k), drdata[k], 32'h0);
      end

      // Instance 0 (no wait states): vector table
      tbl.push_back(mk(0, 1, SZ_W, 32'h10, 32'hDEADBEEF, 0, 32'h0));
      tbl.push_back(mk(1, 0, SZ_W, 32'h10, 32'h0,        0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 1, SZ_W, 32'h10, 32'h11223344, 0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 1, SZ_B, 32'h13, 32'h000000A5, 0, 32'hDEADBEEF));
      tbl.push_back(mk(1, 0, SZ_W, 32'h10, 32'h0,        0, 32'hA5223344));
      tbl.push_back(mk(0, 1, SZ_W, 32'h20, 32'h0,        0, 32'hA5223344));
      tbl.push_back(mk(0, 1, SZ_H, 32'h22, 32'h0000CAFE, 0, 32'hA5223344));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFE0000));
      tbl.push_back(mk(0, 1, SZ_B, 32'h21, 32'h00000077, 0, 32'hCAFE0000));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFE7700));
      tbl.push_back(mk(0, 1, SZ_H, 32'h20, 32'h0000BEEF, 0, 32'hCAFE7700));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFEBEEF));
`ifdef DMEM_MISALIGN_TRAP_EN
      tbl.push_back(mk(0, 1, SZ_W, 32'h21, 32'h12345678, 1, 32'h0));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFEBEEF));
      tbl.push_back(mk(0, 1, SZ_H, 32'h23, 32'h0000ABCD, 1, 32'h0));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFEBEEF));
      tbl.push_back(mk(1, 1, SZ_W, 32'h20, 32'hFFFFFFFF, 1, 32'h0));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hCAFEBEEF));
      hold20 = 32'hCAFEBEEF;
`else
      tbl.push_back(mk(0, 1, SZ_W, 32'h21, 32'h12345678, 0, 32'hCAFEBEEF));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'h12345678));
      tbl.push_back(mk(0, 1, SZ_H, 32'h23, 32'h0000ABCD, 0, 32'h12345678));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hABCD5678));
      tbl.push_back(mk(1, 1, SZ_W, 32'h20, 32'hFFFFFFFF, 1, 32'h0));
      tbl.push_back(mk(1, 0, SZ_W, 32'h20, 32'h0,        0, 32'hABCD5678));
      hold20 = 32'hABCD5678;
`endif
      tbl.push_back(mk(0, 1, SZ_W, 32'h1010, 32'h0BADF00D, 0, hold20));
      tbl.push_back(mk(1, 0, SZ_W, 32'h10,   32'h0,        0, 32'h0BADF00D));
      tbl.push_back(mk(1, 0, SZ_B, 32'h12,   32'h0,        0, 32'h0BADF00D));
      tbl.push_back(mk(0, 1, SZ_B, 32'h10,   32'h000001FF, 0, 32'h0BADF00D));
      tbl.push_back(mk(1, 0, SZ_W, 32'h10,   32'h0,        0, 32'h0BADF0FF));

      foreach (tbl[i]) begin
         do_txn(0, tbl[i].rd, tbl[i].wr, tbl[i].size, tbl[i].addr, tbl[i].wdata,
                tbl[i].err, tbl[i].rdata, $sformatf("vec%0d", i));
      end

      lr = 32'h0BADF0FF;
      for (int i = 0; i < 6; i++) begin
         a = 32'($urandom_range(0, 1023)) << 2;
         d = $urandom;
         do_txn(0, 0, 1, SZ_W, a, d, 0, lr, $sformatf("rnd_wr%0d", i));
         do_txn(0, 1, 0, SZ_W, a, 32'h0, 0, d, $sformatf("rnd_rd%0d", i));
         lr = d;
      end

      // Instance 1 (3 wait states): inputs during WAIT must not matter
      do_txn(1, 0, 1, SZ_W, 32'h30, 32'h600DCAFE, 0, 32'h0, "ws3_wr30");
      do_txn(1, 0, 1, SZ_W, 32'h40, 32'h12121212, 0, 32'h0, "ws3_wr40");
      drd[1] = 1'b1; dwr[1] = 1'b0; dsize[1] = SZ_W; daddr[1] = 32'h30;
      exp_q.push_back({1'b0, 32'h600DCAFE});
      tick();
      for (int c = 1; c <= 3; c++) begin
         check($sformatf("ws3_busy_c%0d", c), 32'(busy[1]), 32'd1);
         check($sformatf("ws3_noready_c%0d", c), 32'(dready[1]), 32'd0);
         drd[1] = c[0]; dwr[1] = 1'b1; dsize[1] = SZ_B;
         daddr[1] = 32'h40; dwdata[1] = 32'hFFFFFFFF;
         tick();
      end
      drd[1] = 1'b0; dwr[1] = 1'b0;
      exp = exp_q.pop_front();
      check("ws3_ready", 32'(dready[1]), 32'd1);
      check("ws3_busy_resp", 32'(busy[1]), 32'd1);
      check("ws3_err", 32'(derr[1]), 32'(exp[32]));
      check("ws3_rdata", drdata[1], exp[31:0]);
      tick();
      check("ws3_pulse_end", 32'(dready[1]), 32'd0);
      check("ws3_idle", 32'(busy[1]), 32'd0);
      do_txn(1, 1, 0, SZ_W, 32'h40, 32'h0, 0, 32'h12121212, "ws3_rd40");

      // Instance 2 (2 wait states): reset during WAIT drops the write
      do_txn(2, 0, 1, SZ_W, 32'h40, 32'hAAAAAAAA, 0, 32'h0, "rst_wr_old");
      do_txn(2, 1, 0, SZ_W, 32'h40, 32'h0, 0, 32'hAAAAAAAA, "rst_rd_old");
      dwr[2] = 1'b1; dsize[2] = SZ_W; daddr[2] = 32'h40; dwdata[2] = 32'h00000055;
      tick();
      dwr[2] = 1'b0;
      check("rst_busy_wait", 32'(busy[2]), 32'd1);
      rst[2] = 1'b1;
      tick();
      rst[2] = 1'b0;
      check("rst_busy", 32'(busy[2]), 32'd0);
      check("rst_drdata", drdata[2], 32'h0);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("rst_noready%0d", c), 32'(dready[2]), 32'd0);
         tick();
      end
      do_txn(2, 1, 0, SZ_W, 32'h40, 32'h0, 0, 32'hAAAAAAAA, "rst_rd_after");

      // Reset in the response cycle: the write already committed
      dwr[2] = 1'b1; dsize[2] = SZ_W; daddr[2] = 32'h40; dwdata[2] = 32'h00000055;
      tick();
      dwr[2] = 1'b0;
      tick();
      tick();
      check("rst_resp_ready", 32'(dready[2]), 32'd1);
      rst[2] = 1'b1;
      tick();
      rst[2] = 1'b0;
      check("rst_resp_idle", 32'(busy[2]), 32'd0);
      do_txn(2, 1, 0, SZ_W, 32'h40, 32'h0, 0, 32'h00000055, "rst_rd_kept");

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
